// File: rtl/block_draw_scheduler.sv
// Rectangle fill sequencer that shares the single VGA pixel-write port between erase and draw requesters.
// Optional DRAW_RR_ARB_EN selects round-robin arbitration instead of fixed erase-over-draw priority.
module block_draw_scheduler #(
  parameter int BLOCK_W = 16,
  parameter int BLOCK_H = 16,
  parameter int X_MAX   = 159,
  parameter int Y_MAX   = 119
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       erase_req,
  input  logic [7:0] erase_x,
  input  logic [6:0] erase_y,
  output logic       erase_ack,
  input  logic       draw_req,
  input  logic [7:0] draw_x,
  input  logic [6:0] draw_y,
  input  logic [2:0] draw_colour,
  output logic       draw_ack,
  output logic       busy,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam int CXW = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam int CYW = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
  localparam logic [CXW-1:0] CX_LAST = CXW'(BLOCK_W - 1);
  localparam logic [CYW-1:0] CY_LAST = CYW'(BLOCK_H - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg;
  logic [CXW-1:0] cx_reg;
  logic [CYW-1:0] cy_reg;
  logic [7:0]     origin_x_reg;
  logic [6:0]     origin_y_reg;
  logic [2:0]     colour_reg;

  logic grant_erase;
  logic grant_draw;

`ifdef DRAW_RR_ARB_EN
  // 1 = draw was granted last; resets to draw so erase wins the first contest.
  logic last_grant_reg;
  assign grant_erase = erase_req & (~draw_req | last_grant_reg);
  assign grant_draw  = draw_req & (~erase_req | ~last_grant_reg);
`else
  assign grant_erase = erase_req;
  assign grant_draw  = draw_req & ~erase_req;
`endif

  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_colour;
  assign sel_x      = grant_erase ? erase_x : draw_x;
  assign sel_y      = grant_erase ? erase_y : draw_y;
  assign sel_colour = grant_erase ? 3'b000 : draw_colour;

  logic           last_col;
  logic           last_px;
  logic [CXW-1:0] cx_next;
  logic [CYW-1:0] cy_next;
  assign last_col = (cx_reg == CX_LAST);
  assign last_px  = last_col && (cy_reg == CY_LAST);
  assign cx_next  = last_col ? '0 : cx_reg + CXW'(1);
  assign cy_next  = last_col ? cy_reg + CYW'(1) : cy_reg;

  // Outputs are registered, so the adder works on the pixel that will be shown next cycle:
  // the fresh origin at grant time, otherwise the latched origin plus the advanced counters.
  logic           in_idle;
  logic [7:0]     base_x;
  logic [6:0]     base_y;
  logic [CXW-1:0] off_x;
  logic [CYW-1:0] off_y;
  logic [8:0]     sum_x;
  logic [7:0]     sum_y;
  logic           in_view;
  assign in_idle = (state_reg == IDLE);
  assign base_x  = in_idle ? sel_x : origin_x_reg;
  assign base_y  = in_idle ? sel_y : origin_y_reg;
  assign off_x   = in_idle ? '0 : cx_next;
  assign off_y   = in_idle ? '0 : cy_next;
  assign sum_x   = {1'b0, base_x} + 9'(off_x);
  assign sum_y   = {1'b0, base_y} + 8'(off_y);
  assign in_view = (sum_x <= 9'(X_MAX)) && (sum_y <= 8'(Y_MAX));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      cx_reg       <= '0;
      cy_reg       <= '0;
      origin_x_reg <= '0;
      origin_y_reg <= '0;
      colour_reg   <= '0;
      erase_ack    <= 1'b0;
      draw_ack     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      vga_x        <= '0;
      vga_y        <= '0;
      vga_colour   <= '0;
      vga_plot     <= 1'b0;
`ifdef DRAW_RR_ARB_EN
      last_grant_reg <= 1'b1;
`endif
    end else begin
      erase_ack <= 1'b0;
      draw_ack  <= 1'b0;
      done      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_erase || grant_draw) begin
            state_reg    <= PLOT;
            origin_x_reg <= sel_x;
            origin_y_reg <= sel_y;
            colour_reg   <= sel_colour;
            cx_reg       <= '0;
            cy_reg       <= '0;
            erase_ack    <= grant_erase;
            draw_ack     <= grant_draw;
            busy         <= 1'b1;
            vga_x        <= sum_x[7:0];
            vga_y        <= sum_y[6:0];
            vga_colour   <= sel_colour;
            vga_plot     <= in_view;
`ifdef DRAW_RR_ARB_EN
            last_grant_reg <= grant_draw;
`endif
          end
        end
        PLOT: begin
          if (last_px) begin
            state_reg  <= DONE;
            done       <= 1'b1;
            cx_reg     <= '0;
            cy_reg     <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
          end else begin
            cx_reg     <= cx_next;
            cy_reg     <= cy_next;
            vga_x      <= sum_x[7:0];
            vga_y      <= sum_y[6:0];
            vga_colour <= colour_reg;
            vga_plot   <= in_view;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg  <= IDLE;
          busy       <= 1'b0;
          vga_x      <= '0;
          vga_y      <= '0;
          vga_colour <= '0;
          vga_plot   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_draw_scheduler.sv
// Directed bench for block_draw_scheduler: fills, arbitration, clipping, reset abort, withdrawn request.
module tb_block_draw_scheduler;

  logic       clk = 1'b0;
  logic       resetn;
  logic       erase_req;
  logic [7:0] erase_x;
  logic [6:0] erase_y;
  logic       erase_ack;
  logic       draw_req;
  logic [7:0] draw_x;
  logic [6:0] draw_y;
  logic [2:0] draw_colour;
  logic       draw_ack;
  logic       busy;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  always #5 clk = ~clk;

  block_draw_scheduler dut (
    .clk        (clk),
    .resetn     (resetn),
    .erase_req  (erase_req),
    .erase_x    (erase_x),
    .erase_y    (erase_y),
    .erase_ack  (erase_ack),
    .draw_req   (draw_req),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .draw_colour(draw_colour),
    .draw_ack   (draw_ack),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Per-window observations, cycle k counted from the cycle in which the request is sampled.
  int ea_first, ea_cnt, da_first, da_cnt, done_first, done_cnt;
  int busy_first, busy_last, busy_cnt;
  int plot_cnt, plot_first, plot_last, plot_win, colour_bad, idle_dirty;
  logic [7:0] fx, lx;
  logic [6:0] fy, ly;

  task automatic observe(input int ncyc, input int win_end, input logic [2:0] exp_colour,
                         input int pulse_on, input int pulse_off);
    ea_first = -1; ea_cnt = 0; da_first = -1; da_cnt = 0;
    done_first = -1; done_cnt = 0; busy_first = -1; busy_last = -1; busy_cnt = 0;
    plot_cnt = 0; plot_first = -1; plot_last = -1; plot_win = 0; colour_bad = 0; idle_dirty = 0;
    fx = '0; fy = '0; lx = '0; ly = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (erase_ack) begin if (ea_first < 0) ea_first = k; ea_cnt++; erase_req = 1'b0; end
      if (draw_ack)  begin if (da_first < 0) da_first = k; da_cnt++; draw_req = 1'b0; end
      if (done) begin if (done_first < 0) done_first = k; done_cnt++; end
      if (busy) begin if (busy_first < 0) busy_first = k; busy_last = k; busy_cnt++; end
      if (vga_plot) begin
        plot_cnt++;
        if (plot_first < 0) begin plot_first = k; fx = vga_x; fy = vga_y; end
        plot_last = k; lx = vga_x; ly = vga_y;
        if (k <= win_end) begin
          plot_win++;
          if (vga_colour !== exp_colour) colour_bad++;
        end
      end
      if ((!busy || done) && (vga_plot || vga_x != 0 || vga_y != 0 || vga_colour != 0))
        idle_dirty++;
      if (k == pulse_on)  draw_req = 1'b1;
      if (k == pulse_off) draw_req = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(tag, busy, 0);
    @(negedge clk);
  endtask

  logic [3:0] grants;
  logic [3:0] exp_order;
  int         ack_cyc [4];
  int         g;
  int         rst_done;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; erase_req = 1'b0; draw_req = 1'b0;
    erase_x = '0; erase_y = '0; draw_x = '0; draw_y = '0; draw_colour = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {erase_ack, draw_ack, busy, done, vga_x, vga_y, vga_colour, vga_plot}, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {erase_ack, draw_ack, busy, done, vga_plot}, 0);

    // Plain draw reaching the bottom visible row.
    draw_x = 8'd0; draw_y = 7'd104; draw_colour = 3'b110; draw_req = 1'b1;
    observe(260, 256, 3'b110, -1, -1);
    check("d_ack_cycle", da_first, 1);
    check("d_ack_count", da_cnt, 1);
    check("d_no_erase_ack", ea_cnt, 0);
    check("d_plot_count", plot_cnt, 256);
    check("d_plot_first_cycle", plot_first, 1);
    check("d_plot_last_cycle", plot_last, 256);
    check("d_first_pixel", {fx, fy}, {8'd0, 7'd104});
    check("d_last_pixel", {lx, ly}, {8'd15, 7'd119});
    check("d_colour", colour_bad, 0);
    check("d_done_cycle", done_first, 257);
    check("d_done_count", done_cnt, 1);
    check("d_busy_first", busy_first, 1);
    check("d_busy_last", busy_last, 257);
    check("d_busy_count", busy_cnt, 257);
    check("d_idle_outputs", idle_dirty, 0);

    // Erase and draw raised together: erase first, draw after DONE.
    erase_x = 8'd144; erase_y = 7'd88; erase_req = 1'b1;
    draw_x = 8'd0; draw_y = 7'd72; draw_colour = 3'b101; draw_req = 1'b1;
    observe(262, 256, 3'b000, -1, -1);
    check("s_erase_ack_cycle", ea_first, 1);
    check("s_plot_in_erase", plot_win, 256);
    check("s_erase_colour", colour_bad, 0);
    check("s_done_cycle", done_first, 257);
    check("s_draw_ack_cycle", da_first, 259);
    check("s_draw_first_pixel", {fx, fy}, {8'd144, 7'd88});
    wait_idle("s_idle_wait");

    // Right-edge clipping: only columns 150..159 strobe.
    draw_x = 8'd150; draw_y = 7'd8; draw_colour = 3'b010; draw_req = 1'b1;
    observe(258, 256, 3'b010, -1, -1);
    check("c_plot_count", plot_cnt, 160);
    check("c_first_pixel", {fx, fy}, {8'd150, 7'd8});
    check("c_last_pixel", {lx, ly}, {8'd159, 7'd23});
    check("c_done_cycle", done_first, 257);
    check("c_busy_count", busy_cnt, 257);

    // Reset during the 41st pixel aborts without a done pulse.
    draw_x = 8'd0; draw_y = 7'd0; draw_colour = 3'b111; draw_req = 1'b1;
    observe(41, 41, 3'b111, -1, -1);
    check("r_plot_before_reset", {vga_plot, vga_x, vga_y}, {1'b1, 8'd8, 7'd2});
    resetn = 1'b0;
    #1;
    check("r_async_drop", {vga_plot, busy, erase_ack, draw_ack, done, vga_x}, 0);
    rst_done = 0;
    repeat (2) begin @(negedge clk); if (done) rst_done++; end
    resetn = 1'b1;
    repeat (2) begin @(negedge clk); if (done) rst_done++; end
    check("r_no_done", rst_done, 0);
    check("r_idle_after", busy, 0);
    draw_x = 8'd20; draw_y = 7'd30; draw_colour = 3'b011; draw_req = 1'b1;
    observe(3, 3, 3'b011, -1, -1);
    check("r_new_ack_cycle", da_first, 1);
    check("r_new_first_pixel", {fx, fy}, {8'd20, 7'd30});
    wait_idle("r_idle_wait");

    // Both requests held for four grants.
    erase_x = 8'd40; erase_y = 7'd40; draw_x = 8'd60; draw_y = 7'd60; draw_colour = 3'b001;
    erase_req = 1'b1; draw_req = 1'b1;
    g = 0; grants = '0;
    for (int k = 1; k <= 1200 && g < 4; k++) begin
      @(negedge clk);
      if (erase_ack) begin grants[g] = 1'b0; ack_cyc[g] = k; g++; end
      else if (draw_ack) begin grants[g] = 1'b1; ack_cyc[g] = k; g++; end
    end
    erase_req = 1'b0; draw_req = 1'b0;
`ifdef DRAW_RR_ARB_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b0000;
`endif
    check("a_grant_count", g, 4);
    check("a_grant_order", grants, exp_order);
    check("a_first_ack", ack_cyc[0], 1);
    check("a_ack_spacing", ack_cyc[1] - ack_cyc[0], 258);
    wait_idle("a_idle_wait");

    // Draw request raised then withdrawn while an erase is in PLOT.
    erase_x = 8'd0; erase_y = 7'd0; erase_req = 1'b1;
    draw_x = 8'd10; draw_y = 7'd10; draw_colour = 3'b100;
    observe(300, 256, 3'b000, 10, 200);
    check("w_erase_ack_cycle", ea_first, 1);
    check("w_no_draw_ack", da_cnt, 0);
    check("w_done_cycle", done_first, 257);
    check("w_busy_last", busy_last, 257);
    check("w_plot_count", plot_cnt, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
